// File: rtl/uart_fifo_bridge.sv
// Byte FIFOs between a host and a UART core, with TX and RX handshake FSMs.
// Define UART_FIFO_OVERRUN_EN to drop on RX-full with a sticky rx_overrun flag.
module uart_fifo_bridge #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tx_wr_en,
  input  logic [7:0]               tx_din,
  output logic                     tx_full,
  output logic [$clog2(DEPTH):0]   tx_count,
  input  logic                     rx_rd_en,
  output logic [7:0]               rx_dout,
  output logic                     rx_empty,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     uart_wr_en,
  output logic [7:0]               uart_din,
  input  logic                     uart_tx_busy,
  input  logic                     uart_rdy,
  output logic                     uart_rdy_clr,
  input  logic [7:0]               uart_dout
`ifdef UART_FIFO_OVERRUN_EN
  ,
  output logic                     rx_overrun,
  input  logic                     overrun_clr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;
  typedef enum logic {RX_IDLE, RX_CLR} rx_state_t;

  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                               input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return cnt + CW'(1);
      2'b01:   return cnt - CW'(1);
      default: return cnt;
    endcase
  endfunction

  // ---------------- TX FIFO and transmit handshake ----------------
  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wptr, r_tx_rptr;
  logic [CW-1:0] r_tx_count;
  logic          r_tx_full;
  tx_state_t     r_tx_state;
  logic          r_uart_wr_en;
  logic [7:0]    r_uart_din;
  logic          w_tx_push, w_tx_pop;
  logic [CW-1:0] w_tx_count_nxt;

  assign w_tx_push      = tx_wr_en && !r_tx_full;
  assign w_tx_pop       = (r_tx_state == TX_IDLE) && (r_tx_count != '0) && !uart_tx_busy;
  assign w_tx_count_nxt = next_count(r_tx_count, w_tx_push, w_tx_pop);

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
      r_tx_full  <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1);
      r_tx_count <= w_tx_count_nxt;
      r_tx_full  <= (w_tx_count_nxt == FULL_CNT);
    end
  end

  // Strobe stays high until the core acknowledges by raising busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state   <= TX_IDLE;
      r_uart_wr_en <= 1'b0;
      r_uart_din   <= 8'h00;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (w_tx_pop) begin
          r_uart_din   <= r_tx_mem[r_tx_rptr];
          r_uart_wr_en <= 1'b1;
          r_tx_state   <= TX_SEND;
        end
        TX_SEND: if (uart_tx_busy) begin
          r_uart_wr_en <= 1'b0;
          r_tx_state   <= TX_WAIT;
        end
        TX_WAIT: if (!uart_tx_busy) r_tx_state <= TX_IDLE;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO and receive handshake ----------------
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wptr, r_rx_rptr;
  logic [CW-1:0] r_rx_count;
  logic          r_rx_empty;
  logic [7:0]    r_rx_dout;
  rx_state_t     r_rx_state;
  logic          r_uart_rdy_clr;
  logic          w_rx_full, w_rx_pop, w_rx_take, w_rx_push, w_rx_ack;
  logic [AW-1:0] w_rx_rptr_nxt;
  logic [CW-1:0] w_rx_count_nxt;
  logic [7:0]    w_rx_head_nxt;

  assign w_rx_full      = (r_rx_count == FULL_CNT);
  assign w_rx_pop       = rx_rd_en && !r_rx_empty;
  assign w_rx_take      = (r_rx_state == RX_IDLE) && uart_rdy;
  assign w_rx_push      = w_rx_take && (!w_rx_full || w_rx_pop);
  assign w_rx_rptr_nxt  = w_rx_pop ? r_rx_rptr + AW'(1) : r_rx_rptr;
  assign w_rx_count_nxt = next_count(r_rx_count, w_rx_push, w_rx_pop);

`ifdef UART_FIFO_OVERRUN_EN
  logic w_rx_drop;
  logic r_rx_overrun;

  assign w_rx_drop  = w_rx_take && w_rx_full && !w_rx_pop;
  assign w_rx_ack   = w_rx_push || w_rx_drop;
  assign rx_overrun = r_rx_overrun;

  // A drop wins over a clear in the same cycle so no loss goes unreported.
  always_ff @(posedge clk) begin
    if (!rst_n)           r_rx_overrun <= 1'b0;
    else if (w_rx_drop)   r_rx_overrun <= 1'b1;
    else if (overrun_clr) r_rx_overrun <= 1'b0;
  end
`else
  assign w_rx_ack = w_rx_push;
`endif

  // Registered show-ahead head: the byte being written lands directly when it becomes head.
  always_comb begin
    w_rx_head_nxt = r_rx_dout;
    if (w_rx_count_nxt != '0) begin
      if (w_rx_push && (r_rx_count == CW'(w_rx_pop))) w_rx_head_nxt = uart_dout;
      else                                              w_rx_head_nxt = r_rx_mem[w_rx_rptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= uart_dout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
      r_rx_empty <= 1'b1;
      r_rx_dout  <= 8'h00;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + AW'(1);
      r_rx_rptr  <= w_rx_rptr_nxt;
      r_rx_count <= w_rx_count_nxt;
      r_rx_empty <= (w_rx_count_nxt == '0);
      r_rx_dout  <= w_rx_head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state     <= RX_IDLE;
      r_uart_rdy_clr <= 1'b0;
    end else begin
      case (r_rx_state)
        RX_IDLE: if (w_rx_ack) begin
          r_uart_rdy_clr <= 1'b1;
          r_rx_state     <= RX_CLR;
        end
        RX_CLR: if (!uart_rdy) begin
          r_uart_rdy_clr <= 1'b0;
          r_rx_state     <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign tx_full      = r_tx_full;
  assign tx_count     = r_tx_count;
  assign uart_wr_en   = r_uart_wr_en;
  assign uart_din     = r_uart_din;
  assign rx_dout      = r_rx_dout;
  assign rx_empty     = r_rx_empty;
  assign rx_count     = r_rx_count;
  assign uart_rdy_clr = r_uart_rdy_clr;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: a per-cycle vector table plus multi-cycle sequences.
// The RX-full sequence follows UART_FIFO_OVERRUN_EN when it is defined.
module tb_uart_fifo_bridge;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_wr_en;
  logic [7:0] tx_din;
  logic       tx_full;
  logic [3:0] tx_count;
  logic       rx_rd_en;
  logic [7:0] rx_dout;
  logic       rx_empty;
  logic [3:0] rx_count;
  logic       uart_wr_en;
  logic [7:0] uart_din;
  logic       uart_tx_busy;
  logic       uart_rdy;
  logic       uart_rdy_clr;
  logic [7:0] uart_dout;
`ifdef UART_FIFO_OVERRUN_EN
  logic       rx_overrun;
  logic       overrun_clr;
`endif

  uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_wr_en(tx_wr_en), .tx_din(tx_din), .tx_full(tx_full), .tx_count(tx_count),
    .rx_rd_en(rx_rd_en), .rx_dout(rx_dout), .rx_empty(rx_empty), .rx_count(rx_count),
    .uart_wr_en(uart_wr_en), .uart_din(uart_din), .uart_tx_busy(uart_tx_busy),
    .uart_rdy(uart_rdy), .uart_rdy_clr(uart_rdy_clr), .uart_dout(uart_dout)
`ifdef UART_FIFO_OVERRUN_EN
    , .rx_overrun(rx_overrun), .overrun_clr(overrun_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic twr; logic [7:0] tdin; logic busy; logic rdy; logic [7:0] udout; logic rd;
    logic [3:0] e_tcnt; logic e_tfull; logic e_wr; logic [7:0] e_udin;
    logic [3:0] e_rcnt; logic e_rempty; logic [7:0] e_rdout; logic e_clr;
  } vec_t;

  vec_t       tbl [17];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] got [$];
  logic [7:0] sb [$];
  int         busy_cnt;
  logic       prev_wr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tx_wr_en = 0; tx_din = 0; rx_rd_en = 0; uart_tx_busy = 0; uart_rdy = 0; uart_dout = 0;
`ifdef UART_FIFO_OVERRUN_EN
    overrun_clr = 0;
`endif
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic chk_reset_state();
    chk("rst_tx_count", tx_count, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_wr_en", uart_wr_en, 0);
    chk("rst_uart_din", uart_din, 0);
    chk("rst_rx_dout", rx_dout, 0);
    chk("rst_rdy_clr", uart_rdy_clr, 0);
`ifdef UART_FIFO_OVERRUN_EN
    chk("rst_overrun", rx_overrun, 0);
`endif
  endtask

  // UART transmitter model: busy for 10 cycles after each accepted strobe.
  task automatic tx_cycle();
    logic busy_before;
    busy_before = uart_tx_busy;
    step();
    if (uart_wr_en && !prev_wr) begin
      got.push_back(uart_din);
      chk("tx_strobe_while_busy", busy_before, 0);
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    prev_wr = uart_wr_en;
    uart_tx_busy = (busy_cnt > 0);
  endtask

  task automatic rx_deliver(input logic [7:0] b);
    uart_rdy = 1; uart_dout = b;
    for (int i = 0; i < 10 && !uart_rdy_clr; i++) step();
    chk("rx_rdy_clr_set", uart_rdy_clr, 1);
    step();
    chk("rx_rdy_clr_hold", uart_rdy_clr, 1);
    uart_rdy = 0;
    for (int i = 0; i < 10 && uart_rdy_clr; i++) step();
    chk("rx_rdy_clr_drop", uart_rdy_clr, 0);
  endtask

  task automatic rx_pop(input logic [7:0] exp);
    chk("rx_dout_order", rx_dout, exp);
    rx_rd_en = 1;
    step();
    rx_rd_en = 0;
  endtask

  initial begin
    //            twr tdin   bsy rdy udout  rd | tcnt full wr udin   rcnt emp rdout  clr
    tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 4'd2, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b1, 8'h11, 4'd0, 1'b1, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b1, 8'h11, 4'd0, 1'b1, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 8'h11, 4'd0, 1'b1, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 8'h11, 4'd0, 1'b1, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 8'h11, 4'd0, 1'b1, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0, 4'd0, 1'b0, 1'b1, 8'h22, 4'd1, 1'b0, 8'h55, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0, 4'd0, 1'b0, 1'b0, 8'h22, 4'd1, 1'b0, 8'h55, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 8'h22, 4'd1, 1'b0, 8'h55, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hAA, 1'b0, 4'd0, 1'b0, 1'b0, 8'h22, 4'd2, 1'b0, 8'h55, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 8'h22, 4'd2, 1'b0, 8'h55, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 8'h22, 4'd1, 1'b0, 8'hAA, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 8'h22, 4'd0, 1'b1, 8'hAA, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 8'h22, 4'd0, 1'b1, 8'hAA, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b1, 4'd0, 1'b0, 1'b0, 8'h22, 4'd1, 1'b0, 8'h3C, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 8'h22, 4'd1, 1'b0, 8'h3C, 1'b0};

    do_reset();
    chk_reset_state();

    for (int r = 0; r < 17; r++) begin
      tx_wr_en = tbl[r].twr; tx_din = tbl[r].tdin; uart_tx_busy = tbl[r].busy;
      uart_rdy = tbl[r].rdy; uart_dout = tbl[r].udout; rx_rd_en = tbl[r].rd;
      step();
      chk($sformatf("v%0d_tx_count", r), tx_count, tbl[r].e_tcnt);
      chk($sformatf("v%0d_tx_full", r), tx_full, tbl[r].e_tfull);
      chk($sformatf("v%0d_wr_en", r), uart_wr_en, tbl[r].e_wr);
      chk($sformatf("v%0d_uart_din", r), uart_din, tbl[r].e_udin);
      chk($sformatf("v%0d_rx_count", r), rx_count, tbl[r].e_rcnt);
      chk($sformatf("v%0d_rx_empty", r), rx_empty, tbl[r].e_rempty);
      chk($sformatf("v%0d_rx_dout", r), rx_dout, tbl[r].e_rdout);
      chk($sformatf("v%0d_rdy_clr", r), uart_rdy_clr, tbl[r].e_clr);
    end

    do_reset();
    chk_reset_state();

    // Three bytes through a slow transmitter.
    got.delete(); busy_cnt = 0; prev_wr = 0;
    for (int i = 0; i < 60; i++) begin
      tx_wr_en = (i < 3); tx_din = 8'h41 + 8'(i);
      tx_cycle();
    end
    tx_wr_en = 0;
    chk("tx3_pulses", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("tx3_data", got[i], 8'h41 + 8'(i));

    // Overfill TX with busy held high.
    do_reset();
    uart_tx_busy = 1;
    for (int i = 0; i < 9; i++) begin
      tx_wr_en = 1; tx_din = 8'h60 + 8'(i);
      step();
      if (i == 6) chk("txfull_at7", tx_full, 0);
      if (i >= 7) begin
        chk("txfull_flag", tx_full, 1);
        chk("txfull_count", tx_count, 8);
      end
      chk("txfull_no_strobe", uart_wr_en, 0);
    end
    tx_wr_en = 0;
    got.delete(); busy_cnt = 0; prev_wr = 0; uart_tx_busy = 0;
    for (int i = 0; i < 130; i++) tx_cycle();
    chk("txfull_drained", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("txfull_data", got[i], 8'h60 + 8'(i));
    chk("txfull_empty", tx_count, 0);

    // Fill RX, then present one more byte.
    do_reset();
    for (int i = 0; i < 8; i++) rx_deliver(8'hB0 + 8'(i));
    chk("rxfull_count", rx_count, 8);
`ifdef UART_FIFO_OVERRUN_EN
    rx_deliver(8'h99);
    chk("ovr_flag", rx_overrun, 1);
    chk("ovr_count", rx_count, 8);
    overrun_clr = 1;
    step();
    overrun_clr = 0;
    chk("ovr_cleared", rx_overrun, 0);
    for (int i = 0; i < 8; i++) rx_pop(8'hB0 + 8'(i));
`else
    uart_rdy = 1; uart_dout = 8'h99;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_no_clr", uart_rdy_clr, 0);
    end
    chk("bp_count", rx_count, 8);
    chk("bp_head", rx_dout, 8'hB0);
    rx_rd_en = 1;
    step();
    rx_rd_en = 0;
    chk("bp_clr_on_pop", uart_rdy_clr, 1);
    chk("bp_count_after", rx_count, 8);
    uart_rdy = 0;
    step();
    chk("bp_clr_drop", uart_rdy_clr, 0);
    for (int i = 1; i < 8; i++) rx_pop(8'hB0 + 8'(i));
    rx_pop(8'h99);
`endif
    chk("rxfull_drained", rx_empty, 1);

    // Pointer wrap with concurrent push and pop at count 4.
    do_reset();
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      rx_deliver(8'h10 + 8'(i));
      sb.push_back(8'h10 + 8'(i));
    end
    for (int i = 4; i < 20; i++) begin
      chk("wrap_head", rx_dout, sb.pop_front());
      uart_rdy = 1; uart_dout = 8'h10 + 8'(i); rx_rd_en = 1;
      sb.push_back(8'h10 + 8'(i));
      step();
      chk("wrap_count", rx_count, 4);
      uart_rdy = 0; rx_rd_en = 0;
      step();
    end
    while (sb.size() > 0) rx_pop(sb.pop_front());
    chk("wrap_empty", rx_empty, 1);

    // Reset while a strobe is outstanding.
    do_reset();
    uart_tx_busy = 1;
    for (int i = 0; i < 4; i++) begin
      tx_wr_en = 1; tx_din = 8'hC0 + 8'(i);
      step();
    end
    tx_wr_en = 0; uart_tx_busy = 0;
    step();
    chk("mr_send_wr", uart_wr_en, 1);
    chk("mr_queued", tx_count, 3);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mr_count", tx_count, 0);
    chk("mr_wr_en", uart_wr_en, 0);
    begin
      int pulses = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (uart_wr_en) pulses++;
      end
      chk("mr_no_pulses", pulses, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_fifo_bridge.md
UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 Parameter: DEPTH, default 8, entries per FIFO; SHALL be a power of two, 2 to 256.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_n  in  1  synchronous active-low reset.
REQ-005 Port: tx_wr_en  in  1  push tx_din into the TX FIFO.
REQ-006 Port: tx_din  in  8  TX byte.
REQ-007 Port: tx_full  out  1  TX FIFO holds DEPTH entries.
REQ-008 Port: tx_count  out  log2(DEPTH)+1  TX FIFO occupancy.
REQ-009 Port: rx_rd_en  in  1  pop the RX FIFO head.
REQ-010 Port: rx_dout  out  8  RX FIFO head, show-ahead.
REQ-011 Port: rx_empty  out  1  RX FIFO holds no entries.
REQ-012 Port: rx_count  out  log2(DEPTH)+1  RX FIFO occupancy.
REQ-013 Port: uart_wr_en  out  1  UART core transmit strobe.
REQ-014 Port: uart_din  out  8  UART core transmit byte.
REQ-015 Port: uart_tx_busy  in  1  UART core transmitter busy.
REQ-016 Port: uart_rdy  in  1  UART core has a received byte.
REQ-017 Port: uart_rdy_clr  out  1  acknowledge received byte to the UART core.
REQ-018 Port: uart_dout  in  8  UART core received byte.
REQ-019 Port: rx_overrun  out  1  sticky drop flag; present only with UART_FIFO_OVERRUN_EN.
REQ-020 Port: overrun_clr  in  1  clears rx_overrun; present only with UART_FIFO_OVERRUN_EN.

Function
REQ-021 Both FIFOs SHALL be circular buffers with wrapping pointers; occupancy SHALL be held as a count.
REQ-022 A push while full SHALL be ignored, with no change to state. A pop while empty SHALL be ignored, and rx_dout SHALL hold its value.
REQ-023 A simultaneous push and pop on a non-empty, non-full FIFO SHALL leave the count unchanged.
REQ-024 Each push SHALL become visible at the FIFO outputs the cycle after it is accepted.
REQ-025 The TX state machine SHALL have the states TX_IDLE, TX_SEND and TX_WAIT.
REQ-026 TX_IDLE -> TX_SEND when the TX FIFO is non-empty and uart_tx_busy=0; that cycle SHALL register uart_din=head, set uart_wr_en=1 and pop the head.
REQ-027 TX_SEND SHALL hold uart_wr_en=1 until uart_tx_busy=1; it then clears uart_wr_en and moves to TX_WAIT.
REQ-028 TX_WAIT -> TX_IDLE when uart_tx_busy=0; minimum spacing is 3 cycles from one uart_wr_en rise to the next.
REQ-029 The RX state machine SHALL have the states RX_IDLE and RX_CLR.
REQ-030 In RX_IDLE with uart_rdy=1 and the RX FIFO not full, or popped the same cycle: push uart_dout, then go to RX_CLR with uart_rdy_clr=1.
REQ-031 RX_CLR SHALL hold uart_rdy_clr=1 until uart_rdy=0, then return to RX_IDLE with uart_rdy_clr=0; no second push SHALL occur for the same byte.
REQ-032 The full-RX-FIFO case is governed by REQ-040 and REQ-041.
REQ-033 All outputs SHALL be registered; the TX and RX paths SHALL be fully independent.

Reset
REQ-034 With rst_n=0 at a clock edge, both FIFOs SHALL be emptied: counts 0, pointers 0, tx_full=0, rx_empty=1.
REQ-035 Reset SHALL force TX_IDLE and RX_IDLE with uart_wr_en=0, uart_rdy_clr=0, uart_din=0, rx_dout=0 and rx_overrun=0.
REQ-036 Reset mid-transfer SHALL abandon the byte in flight without a retry, and SHALL NOT wait for uart_tx_busy to clear.
REQ-037 The first action after reset SHALL occur no earlier than the first edge with rst_n=1.

Configuration
REQ-038 The macro UART_FIFO_OVERRUN_EN SHALL select the RX-full policy.
REQ-039 The TX path SHALL be identical with and without the macro.
REQ-040 With UART_FIFO_OVERRUN_EN defined, the full-RX-FIFO case (uart_rdy=1, FIFO full, no concurrent pop) SHALL drop the byte, set rx_overrun=1 and enter RX_CLR. rx_overrun SHALL stay set until overrun_clr=1; a drop coinciding with a clear SHALL leave rx_overrun set.
REQ-041 Without the macro, the full-RX-FIFO case SHALL remain in RX_IDLE with uart_rdy_clr=0 (backpressure), and the rx_overrun and overrun_clr ports SHALL be absent.

Verification
REQ-042 Push 0x41,0x42,0x43 while uart_tx_busy is modelled 1 for 10 cycles after each strobe -> three uart_wr_en pulses carrying 0x41,0x42,0x43 in order, none while busy.
REQ-043 DEPTH=8: push 9 bytes back-to-back with uart_tx_busy held 1 -> tx_full=1 after 8 pushes and tx_count=8, and the 9th byte never appears on uart_din.
REQ-044 UART delivers 0x55 then 0xAA -> uart_rdy_clr held until uart_rdy falls after each byte, rx_count=2, and rx_dout=0x55, then 0xAA after one pop.
REQ-045 With the macro, fill the RX FIFO to 8 and deliver 0x99 -> byte dropped, rx_overrun=1, rdy cleared, rx_count=8; overrun_clr -> rx_overrun=0. Without the macro -> uart_rdy_clr stays 0 until a pop, then 0x99 is pushed.
REQ-046 Wrap and simultaneous events: 20 pushes and pops with a concurrent push+pop at count=4 -> count stays 4, data order is preserved across the pointer wrap.
REQ-047 Reset mid-operation: rst_n=0 for 1 cycle during TX_SEND with 3 bytes queued -> next cycle tx_count=0, uart_wr_en=0, and no further uart_wr_en pulses.
